// File: rtl/mc_cu_pkg.sv
// Shared constants and types for the multi-cycle MIPS-subset control unit:
// opcode/func codes, ALU and PC-source encodings, FSM states and decode bundle.
package mc_cu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_GT  = 6'b100111;

  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;
  localparam logic [3:0] ALUC_GT  = 4'b1100;

  localparam logic [1:0] PCS_PC4 = 2'b00;
  localparam logic [1:0] PCS_BR  = 2'b01;
  localparam logic [1:0] PCS_JR  = 2'b10;
  localparam logic [1:0] PCS_JMP = 2'b11;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  typedef struct packed {
    logic       legal;
    logic       is_j;
    logic       is_jal;
    logic       is_jr;
    logic       is_beq;
    logic       is_bne;
    logic       is_lw;
    logic       is_sw;
    logic [3:0] aluc;
    logic       shift;
    logic       aluimm;
    logic       sext;
    logic       regrt;
    logic       jal;
  } dec_t;

endpackage

// File: rtl/mc_cu_if.sv
// Shared instruction/data memory handshake between the control unit and memory.
interface mc_cu_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_rdy;

  modport master (output mem_req, output mem_we, output iord, input mem_rdy);
  modport slave  (input mem_req, input mem_we, input iord, output mem_rdy);
endinterface

// File: rtl/mc_cu_decode.sv
// Purely combinational instruction decode: class flags, static datapath
// controls and legality for the supported MIPS subset.
module mc_decode
  import mc_cu_pkg::*;
#(
  parameter bit EN_GT = 1'b1
) (
  input  logic [5:0] i_op,
  input  logic [5:0] i_func,
  output dec_t       o_dec
);

  // NOTE: every field gets a default before the case so no path leaves a latch.
  always_comb begin
    o_dec = '0;
    case (i_op)
      OP_RTYPE: begin
        o_dec.legal = 1'b1;
        case (i_func)
          FN_ADD: o_dec.aluc = ALUC_ADD;
          FN_SUB: o_dec.aluc = ALUC_SUB;
          FN_AND: o_dec.aluc = ALUC_AND;
          FN_OR:  o_dec.aluc = ALUC_OR;
          FN_XOR: o_dec.aluc = ALUC_XOR;
          FN_SLL: begin o_dec.aluc = ALUC_SLL; o_dec.shift = 1'b1; end
          FN_SRL: begin o_dec.aluc = ALUC_SRL; o_dec.shift = 1'b1; end
          FN_SRA: begin o_dec.aluc = ALUC_SRA; o_dec.shift = 1'b1; end
          FN_JR:  o_dec.is_jr = 1'b1;
          FN_GT:  begin o_dec.aluc = ALUC_GT; o_dec.legal = EN_GT; end
          default: o_dec.legal = 1'b0;
        endcase
      end
      OP_ADDI: begin
        o_dec.legal = 1'b1; o_dec.aluc = ALUC_ADD;
        o_dec.aluimm = 1'b1; o_dec.sext = 1'b1; o_dec.regrt = 1'b1;
      end
      OP_ANDI: begin
        o_dec.legal = 1'b1; o_dec.aluc = ALUC_AND; o_dec.aluimm = 1'b1; o_dec.regrt = 1'b1;
      end
      OP_ORI: begin
        o_dec.legal = 1'b1; o_dec.aluc = ALUC_OR; o_dec.aluimm = 1'b1; o_dec.regrt = 1'b1;
      end
      OP_XORI: begin
        o_dec.legal = 1'b1; o_dec.aluc = ALUC_XOR; o_dec.aluimm = 1'b1; o_dec.regrt = 1'b1;
      end
      OP_LUI: begin
        o_dec.legal = 1'b1; o_dec.aluc = ALUC_LUI; o_dec.aluimm = 1'b1; o_dec.regrt = 1'b1;
      end
      OP_LW: begin
        o_dec.legal = 1'b1; o_dec.is_lw = 1'b1; o_dec.aluc = ALUC_ADD;
        o_dec.aluimm = 1'b1; o_dec.sext = 1'b1; o_dec.regrt = 1'b1;
      end
      OP_SW: begin
        o_dec.legal = 1'b1; o_dec.is_sw = 1'b1; o_dec.aluc = ALUC_ADD;
        o_dec.aluimm = 1'b1; o_dec.sext = 1'b1;
      end
      OP_BEQ: begin
        o_dec.legal = 1'b1; o_dec.is_beq = 1'b1; o_dec.aluc = ALUC_SUB; o_dec.sext = 1'b1;
      end
      OP_BNE: begin
        o_dec.legal = 1'b1; o_dec.is_bne = 1'b1; o_dec.aluc = ALUC_SUB; o_dec.sext = 1'b1;
      end
      OP_J:   begin o_dec.legal = 1'b1; o_dec.is_j = 1'b1; end
      OP_JAL: begin o_dec.legal = 1'b1; o_dec.is_jal = 1'b1; o_dec.jal = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_cu.sv
// Multi-cycle control unit: IF/ID/EX/MEM/WB sequencer over a shared memory
// with ready handshake, wait timeout, illegal-op flag and retire counter.
module mc_cu
  import mc_cu_pkg::*;
#(
  parameter bit          EN_GT    = 1'b1,
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             z,
  mc_cu_if.master          bus,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pcsource,
  output logic             wreg,
  output logic             regrt,
  output logic             m2reg,
  output logic             shift,
  output logic             aluimm,
  output logic             sext,
  output logic             jal,
  output logic [3:0]       aluc,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state
);

  localparam int unsigned WAIT_W = $clog2(WAIT_MAX + 1);

  state_t            r_state;
  state_t            w_next;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_instret;
  dec_t              w_dec;
  logic              w_retire;
  logic              w_wait_max;

  mc_decode #(.EN_GT(EN_GT)) u_decode (
    .i_op   (op),
    .i_func (func),
    .o_dec  (w_dec)
  );

  assign w_wait_max = (r_wait == WAIT_W'(WAIT_MAX));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IF;
      r_wait    <= '0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      // Counts stalled request cycles; any phase exit (ready or timeout) clears it.
      if (bus.mem_req && !bus.mem_rdy && !w_wait_max) r_wait <= r_wait + 1'b1;
      else                                            r_wait <= '0;
      if (w_retire) r_instret <= r_instret + 1'b1;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_retire    = 1'b0;
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;
    bus.iord    = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pcsource    = PCS_PC4;
    wreg        = 1'b0;
    m2reg       = 1'b0;
    illegal     = 1'b0;
    bus_err     = 1'b0;
    // Gating on resetn drops the memory request asynchronously mid-transaction.
    if (resetn) begin
      case (r_state)
        S_IF: begin
          bus.mem_req = 1'b1;
          if (bus.mem_rdy) begin
            ir_we  = 1'b1;
            pc_we  = 1'b1;
            w_next = S_ID;
          end else if (w_wait_max) begin
            bus_err = 1'b1;
            w_next  = S_IF;
          end
        end
        S_ID: begin
          if (w_dec.is_j || w_dec.is_jal || w_dec.is_jr) begin
            pc_we    = 1'b1;
            pcsource = w_dec.is_jr ? PCS_JR : PCS_JMP;
            wreg     = w_dec.is_jal;
            w_retire = 1'b1;
            w_next   = S_IF;
          end else if (!w_dec.legal) begin
            illegal = 1'b1;
            w_next  = S_IF;
          end else begin
            w_next = S_EX;
          end
        end
        S_EX: begin
          if (w_dec.is_beq || w_dec.is_bne) begin
            pcsource = PCS_BR;
            pc_we    = (w_dec.is_beq & z) | (w_dec.is_bne & ~z);
            w_retire = 1'b1;
            w_next   = S_IF;
          end else if (w_dec.is_lw || w_dec.is_sw) begin
            w_next = S_MEM;
          end else begin
            w_next = S_WB;
          end
        end
        S_MEM: begin
          bus.mem_req = 1'b1;
          bus.iord    = 1'b1;
          bus.mem_we  = w_dec.is_sw;
          if (bus.mem_rdy) begin
            w_retire = w_dec.is_sw;
            w_next   = w_dec.is_sw ? S_IF : S_WB;
          end else if (w_wait_max) begin
            bus_err = 1'b1;
            w_next  = S_IF;
          end
        end
        S_WB: begin
          wreg     = 1'b1;
          m2reg    = w_dec.is_lw;
          w_retire = 1'b1;
          w_next   = S_IF;
        end
        default: w_next = S_IF;
      endcase
    end
  end

  assign aluc    = resetn ? w_dec.aluc : 4'b0000;
  assign shift   = resetn & w_dec.shift;
  assign aluimm  = resetn & w_dec.aluimm;
  assign sext    = resetn & w_dec.sext;
  assign regrt   = resetn & w_dec.regrt;
  assign jal     = resetn & w_dec.jal;
  assign instret = r_instret;
  assign state   = r_state;

endmodule

// File: tb/tb_mc_cu.sv
// Directed bench for mc_cu: two instances (gt enabled / disabled) share stimulus;
// inputs change just after posedge, outputs are sampled at negedge.
module tb_mc_cu;

  logic        clock   = 1'b0;
  logic        resetn  = 1'b0;
  logic [5:0]  op      = 6'd0;
  logic [5:0]  func    = 6'd0;
  logic        z       = 1'b0;
  logic        mem_rdy = 1'b0;
  int          total   = 0;
  int          bad     = 0;

  always #5 clock = ~clock;

  mc_cu_if bus_a ();
  mc_cu_if bus_b ();
  assign bus_a.mem_rdy = mem_rdy;
  assign bus_b.mem_rdy = mem_rdy;

  logic        a_ir_we, a_pc_we, a_wreg, a_regrt, a_m2reg, a_shift, a_aluimm, a_sext, a_jal;
  logic        a_illegal, a_bus_err;
  logic [1:0]  a_pcsource;
  logic [3:0]  a_aluc;
  logic [31:0] a_instret;
  logic [2:0]  a_state;
  logic        b_ir_we, b_pc_we, b_wreg, b_regrt, b_m2reg, b_shift, b_aluimm, b_sext, b_jal;
  logic        b_illegal, b_bus_err;
  logic [1:0]  b_pcsource;
  logic [3:0]  b_aluc;
  logic [31:0] b_instret;
  logic [2:0]  b_state;

  mc_cu #(.EN_GT(1'b1), .WAIT_MAX(15), .CNT_W(32)) dut_a (
    .clock(clock), .resetn(resetn), .op(op), .func(func), .z(z), .bus(bus_a),
    .ir_we(a_ir_we), .pc_we(a_pc_we), .pcsource(a_pcsource), .wreg(a_wreg),
    .regrt(a_regrt), .m2reg(a_m2reg), .shift(a_shift), .aluimm(a_aluimm),
    .sext(a_sext), .jal(a_jal), .aluc(a_aluc), .illegal(a_illegal),
    .bus_err(a_bus_err), .instret(a_instret), .state(a_state)
  );

  mc_cu #(.EN_GT(1'b0), .WAIT_MAX(15), .CNT_W(32)) dut_b (
    .clock(clock), .resetn(resetn), .op(op), .func(func), .z(z), .bus(bus_b),
    .ir_we(b_ir_we), .pc_we(b_pc_we), .pcsource(b_pcsource), .wreg(b_wreg),
    .regrt(b_regrt), .m2reg(b_m2reg), .shift(b_shift), .aluimm(b_aluimm),
    .sext(b_sext), .jal(b_jal), .aluc(b_aluc), .illegal(b_illegal),
    .bus_err(b_bus_err), .instret(b_instret), .state(b_state)
  );

  // ctl = {mem_req, mem_we, iord, ir_we, pc_we, pcsource[1:0], wreg, m2reg, illegal, bus_err, state[2:0]}
  wire [13:0] a_ctl = {bus_a.mem_req, bus_a.mem_we, bus_a.iord, a_ir_we, a_pc_we, a_pcsource,
                       a_wreg, a_m2reg, a_illegal, a_bus_err, a_state};
  wire [13:0] b_ctl = {bus_b.mem_req, bus_b.mem_we, bus_b.iord, b_ir_we, b_pc_we, b_pcsource,
                       b_wreg, b_m2reg, b_illegal, b_bus_err, b_state};
  // stat = {aluc[3:0], shift, aluimm, sext, regrt}
  wire [7:0]  a_stat = {a_aluc, a_shift, a_aluimm, a_sext, a_regrt};
  wire [7:0]  b_stat = {b_aluc, b_shift, b_aluimm, b_sext, b_regrt};

  localparam logic [13:0] CTL_IDLE_IF = 14'b1_0_0_0_0_00_0_0_0_0_000;
  localparam logic [13:0] CTL_FETCH   = 14'b1_0_0_1_1_00_0_0_0_0_000;

  task automatic apply_reset();
    resetn  = 1'b0;
    mem_rdy = 1'b0;
    z       = 1'b0;
    @(negedge clock);
  endtask

  task automatic release_reset(input logic rdy);
    @(posedge clock); #1;
    resetn  = 1'b1;
    mem_rdy = rdy;
    @(negedge clock);
  endtask

  task automatic next_cycle(input logic rdy);
    @(posedge clock); #1;
    mem_rdy = rdy;
    @(negedge clock);
  endtask

  task automatic test_reset();
    resetn = 1'b0; mem_rdy = 1'b1; op = 6'h23; func = 6'h00;
    @(negedge clock); @(negedge clock);
    total++;
    if (a_ctl !== 14'd0) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", a_ctl, 14'd0); end
    total++;
    if ({a_stat, a_jal} !== 9'd0) begin bad++; $display("FAIL reset_static got=%b exp=0", {a_stat, a_jal}); end
    total++;
    if (a_instret !== 32'd0) begin bad++; $display("FAIL reset_instret got=%0d exp=0", a_instret); end
    release_reset(1'b0);
    total++;
    if (a_ctl !== CTL_IDLE_IF) begin bad++; $display("FAIL reset_first_req got=%b exp=%b", a_ctl, CTL_IDLE_IF); end
  endtask

  task automatic test_add();
    logic [13:0] exp_ctl [5] = '{CTL_FETCH, 14'b0_0_0_0_0_00_0_0_0_0_001,
                                 14'b0_0_0_0_0_00_0_0_0_0_010, 14'b0_0_0_0_0_00_1_0_0_0_100, CTL_FETCH};
    logic [31:0] exp_ret [5] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1};
    apply_reset();
    op = 6'h00; func = 6'h20;
    release_reset(1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) next_cycle(1'b1);
      total++;
      if (a_ctl !== exp_ctl[i]) begin bad++; $display("FAIL add_c%0d_ctl got=%b exp=%b", i + 1, a_ctl, exp_ctl[i]); end
      total++;
      if (a_instret !== exp_ret[i]) begin bad++; $display("FAIL add_c%0d_instret got=%0d exp=%0d", i + 1, a_instret, exp_ret[i]); end
    end
  endtask

  task automatic test_lw_wait();
    logic        rdy     [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [13:0] exp_ctl [9] = '{CTL_FETCH, 14'b0_0_0_0_0_00_0_0_0_0_001, 14'b0_0_0_0_0_00_0_0_0_0_010,
                                 14'b1_0_1_0_0_00_0_0_0_0_011, 14'b1_0_1_0_0_00_0_0_0_0_011,
                                 14'b1_0_1_0_0_00_0_0_0_0_011, 14'b1_0_1_0_0_00_0_0_0_0_011,
                                 14'b0_0_0_0_0_00_1_1_0_0_100, CTL_IDLE_IF};
    logic seen_we = 1'b0;
    apply_reset();
    op = 6'h23; func = 6'h00;
    release_reset(rdy[0]);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) next_cycle(rdy[i]);
      seen_we |= bus_a.mem_we;
      total++;
      if (a_ctl !== exp_ctl[i]) begin bad++; $display("FAIL lw_c%0d_ctl got=%b exp=%b", i + 1, a_ctl, exp_ctl[i]); end
      if (i == 2) begin
        total++;
        if (a_stat !== 8'b0000_0111) begin bad++; $display("FAIL lw_static got=%b exp=%b", a_stat, 8'b0000_0111); end
      end
    end
    total++;
    if (seen_we !== 1'b0) begin bad++; $display("FAIL lw_mem_we got=%b exp=0", seen_we); end
    total++;
    if (a_instret !== 32'd1) begin bad++; $display("FAIL lw_instret got=%0d exp=1", a_instret); end
  endtask

  task automatic test_branch();
    // {op, z, expected pc_we}
    logic [7:0] cases [4] = '{{6'h04, 1'b1, 1'b1}, {6'h04, 1'b0, 1'b0},
                              {6'h05, 1'b1, 1'b0}, {6'h05, 1'b0, 1'b1}};
    logic [7:0]  c;
    logic [13:0] exp;
    for (int k = 0; k < 4; k++) begin
      c = cases[k];
      apply_reset();
      op = c[7:2]; func = 6'h00; z = c[1];
      release_reset(1'b1);
      next_cycle(1'b1);
      next_cycle(1'b1);
      exp = {4'b0000, c[0], 2'b01, 1'b0, 3'b000, 3'b010};
      total++;
      if (a_ctl !== exp) begin bad++; $display("FAIL branch%0d_ex got=%b exp=%b", k, a_ctl, exp); end
      next_cycle(1'b0);
      total++;
      if ({a_state, a_instret} !== {3'd0, 32'd1}) begin
        bad++; $display("FAIL branch%0d_retire state=%0d instret=%0d exp 0/1", k, a_state, a_instret);
      end
    end
  endtask

  task automatic test_jump();
    // {op, func, pcsource, wreg/jal}
    logic [14:0] cases [3] = '{{6'h02, 6'h00, 2'b11, 1'b0}, {6'h03, 6'h00, 2'b11, 1'b1},
                               {6'h00, 6'h08, 2'b10, 1'b0}};
    logic [14:0] c;
    logic [13:0] exp;
    for (int k = 0; k < 3; k++) begin
      c = cases[k];
      apply_reset();
      op = c[14:9]; func = c[8:3];
      release_reset(1'b1);
      next_cycle(1'b0);
      exp = {5'b00001, c[2:1], c[0], 3'b000, 3'b001};
      total++;
      if ({a_ctl, a_jal} !== {exp, c[0]}) begin
        bad++; $display("FAIL jump%0d_id got=%b exp=%b", k, {a_ctl, a_jal}, {exp, c[0]});
      end
      next_cycle(1'b0);
      total++;
      if ({a_ctl, a_instret} !== {CTL_IDLE_IF, 32'd1}) begin
        bad++; $display("FAIL jump%0d_retire ctl=%b instret=%0d", k, a_ctl, a_instret);
      end
    end
  endtask

  task automatic test_timeout();
    int pulses = 0;
    logic [13:0] exp;
    apply_reset();
    op = 6'h00; func = 6'h20;
    release_reset(1'b0);
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) next_cycle(1'b0);
      exp = (c == 16) ? 14'b1_0_0_0_0_00_0_0_0_1_000 : CTL_IDLE_IF;
      if (a_bus_err) pulses++;
      total++;
      if (a_ctl !== exp) begin bad++; $display("FAIL timeout_c%0d got=%b exp=%b", c, a_ctl, exp); end
    end
    for (int c = 17; c <= 31; c++) begin
      next_cycle(1'b0);
      if (a_bus_err) pulses++;
    end
    total++;
    if (pulses !== 1) begin bad++; $display("FAIL timeout_pulses got=%0d exp=1", pulses); end
    total++;
    if ({a_ctl, a_instret} !== {CTL_IDLE_IF, 32'd0}) begin
      bad++; $display("FAIL timeout_refetch ctl=%b instret=%0d", a_ctl, a_instret);
    end
    next_cycle(1'b1);
    total++;
    if (a_ctl !== CTL_FETCH) begin bad++; $display("FAIL timeout_rdy_wins got=%b exp=%b", a_ctl, CTL_FETCH); end
    next_cycle(1'b0);
    total++;
    if (a_state !== 3'd1) begin bad++; $display("FAIL timeout_to_id got=%0d exp=1", a_state); end
  endtask

  task automatic test_gt_illegal();
    apply_reset();
    op = 6'h00; func = 6'h27;
    release_reset(1'b1);
    next_cycle(1'b0);
    total++;
    if ({b_ctl, a_ctl} !== {14'b0_0_0_0_0_00_0_0_1_0_001, 14'b0_0_0_0_0_00_0_0_0_0_001}) begin
      bad++; $display("FAIL gt_id b=%b a=%b", b_ctl, a_ctl);
    end
    next_cycle(1'b0);
    total++;
    if ({a_state, a_aluc, b_ctl} !== {3'd2, 4'b1100, CTL_IDLE_IF}) begin
      bad++; $display("FAIL gt_ex a_state=%0d a_aluc=%b b_ctl=%b", a_state, a_aluc, b_ctl);
    end
    next_cycle(1'b0);
    total++;
    if (a_ctl !== 14'b0_0_0_0_0_00_1_0_0_0_100) begin bad++; $display("FAIL gt_wb got=%b", a_ctl); end
    next_cycle(1'b0);
    total++;
    if ({a_instret, b_instret} !== {32'd1, 32'd0}) begin
      bad++; $display("FAIL gt_instret a=%0d b=%0d exp 1/0", a_instret, b_instret);
    end
    apply_reset();
    op = 6'h3f; func = 6'h00;
    release_reset(1'b1);
    next_cycle(1'b0);
    total++;
    if (a_ctl !== 14'b0_0_0_0_0_00_0_0_1_0_001) begin bad++; $display("FAIL badop_id got=%b", a_ctl); end
    next_cycle(1'b0);
    total++;
    if ({a_state, a_instret} !== {3'd0, 32'd0}) begin
      bad++; $display("FAIL badop_after state=%0d instret=%0d", a_state, a_instret);
    end
  endtask

  task automatic test_reset_mid_mem();
    apply_reset();
    op = 6'h02; func = 6'h00;
    release_reset(1'b1);
    next_cycle(1'b1);
    next_cycle(1'b1);
    op = 6'h2b;
    next_cycle(1'b0);
    next_cycle(1'b0);
    next_cycle(1'b0);
    total++;
    if ({a_ctl, a_instret} !== {14'b1_1_1_0_0_00_0_0_0_0_011, 32'd1}) begin
      bad++; $display("FAIL sw_mem ctl=%b instret=%0d", a_ctl, a_instret);
    end
    next_cycle(1'b0);
    #2 resetn = 1'b0;
    #1;
    total++;
    if ({a_ctl, a_instret} !== {14'd0, 32'd0}) begin
      bad++; $display("FAIL sw_async_reset ctl=%b instret=%0d", a_ctl, a_instret);
    end
    @(negedge clock);
    release_reset(1'b1);
    total++;
    if (a_ctl !== CTL_FETCH) begin bad++; $display("FAIL sw_restart got=%b exp=%b", a_ctl, CTL_FETCH); end
    next_cycle(1'b0);
    total++;
    if ({a_state, a_instret} !== {3'd1, 32'd0}) begin
      bad++; $display("FAIL sw_restart_id state=%0d instret=%0d", a_state, a_instret);
    end
  endtask

  task automatic test_static_decode();
    // {op, func, aluc, shift, aluimm, sext, regrt}
    logic [19:0] tbl [15] = '{
      {6'h00, 6'h20, 4'b0000, 4'b0000}, {6'h00, 6'h22, 4'b0100, 4'b0000},
      {6'h00, 6'h24, 4'b0001, 4'b0000}, {6'h00, 6'h25, 4'b0101, 4'b0000},
      {6'h00, 6'h26, 4'b0010, 4'b0000}, {6'h00, 6'h00, 4'b0011, 4'b1000},
      {6'h00, 6'h02, 4'b0111, 4'b1000}, {6'h00, 6'h03, 4'b1111, 4'b1000},
      {6'h08, 6'h00, 4'b0000, 4'b0111}, {6'h0c, 6'h00, 4'b0001, 4'b0101},
      {6'h0d, 6'h00, 4'b0101, 4'b0101}, {6'h0e, 6'h00, 4'b0010, 4'b0101},
      {6'h0f, 6'h00, 4'b0110, 4'b0101}, {6'h2b, 6'h00, 4'b0000, 4'b0110},
      {6'h04, 6'h00, 4'b0100, 4'b0010}};
    logic [19:0] v;
    apply_reset();
    release_reset(1'b0);
    for (int i = 0; i < 15; i++) begin
      if (i > 0) next_cycle(1'b0);
      v = tbl[i];
      op = v[19:14]; func = v[13:8];
      #1;
      total++;
      if ({a_stat, b_stat} !== {v[7:0], v[7:0]}) begin
        bad++; $display("FAIL decode%0d op=%h func=%h a=%b b=%b exp=%b", i, op, func, a_stat, b_stat, v[7:0]);
      end
    end
    total++;
    if (b_jal !== 1'b0) begin bad++; $display("FAIL decode_jal got=%b exp=0", b_jal); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] ins  [2] = '{{6'h00, 6'h22}, {6'h00, 6'h25}};
    logic [3:0]  aluc [2] = '{4'b0100, 4'b0101};
    logic [11:0] v;
    apply_reset();
    v = ins[0]; op = v[11:6]; func = v[5:0];
    release_reset(1'b1);
    for (int k = 0; k < 2; k++) begin
      if (k > 0) begin
        next_cycle(1'b1);
        v = ins[k]; op = v[11:6]; func = v[5:0];
      end
      next_cycle(1'b0);
      next_cycle(1'b0);
      total++;
      if ({a_state, a_aluc} !== {3'd2, aluc[k]}) begin
        bad++; $display("FAIL b2b%0d_ex state=%0d aluc=%b exp 2/%b", k, a_state, a_aluc, aluc[k]);
      end
      next_cycle(1'b0);
    end
    next_cycle(1'b0);
    total++;
    if (a_instret !== 32'd2) begin bad++; $display("FAIL b2b_instret got=%0d exp=2", a_instret); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_branch();
    test_jump();
    test_timeout();
    test_gt_illegal();
    test_reset_mid_mem();
    test_static_decode();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
